// File: rtl/fmlbrg_tagctl.sv
// fmlbrg_tagctl: tag lookup, write-back/refill burst sequencing and tag update for the FML bridge
module fmlbrg_tagctl #(
  parameter int fml_depth = 26,
  parameter int depth = 9,
  parameter int offset_width = 5,
  localparam int tag_width = fml_depth - depth - offset_width
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   req_stb,
  input  logic                   req_we,
  input  logic [fml_depth-1:0]   req_adr,
  output logic                   req_ack,
  output logic [depth-1:0]       tm_a,
  output logic                   tm_we,
  output logic [tag_width+1:0]   tm_di,
  input  logic [tag_width+1:0]   tm_do,
  output logic [fml_depth-1:0]   fml_adr,
  output logic                   fml_stb,
  output logic                   fml_we,
  input  logic                   fml_ack,
  output logic                   dm_re,
  output logic                   dm_we,
  output logic [1:0]             dm_beat
);
  typedef enum logic [2:0] {IDLE, TEST, EVICT, EVICT_BURST, REFILL, REFILL_BURST, UPDATE} state_t;
  state_t state;
  logic [depth-1:0] index;
  logic [depth-1:0] tm_a_q;
  logic [tag_width-1:0] tag;
  logic hit;
  logic dirty;
  logic unused_ok;
  assign index = req_adr[offset_width+depth-1:offset_width];
  assign tag = req_adr[fml_depth-1:fml_depth-tag_width];
  assign unused_ok = ^req_adr[offset_width-1:0];
  assign hit = tm_do[tag_width+1] && tm_do[tag_width-1:0] == tag;
  assign dirty = tm_do[tag_width];
  assign tm_a = (state == IDLE && !req_stb) ? tm_a_q : index;
  assign dm_re = (state == EVICT && fml_ack) || state == EVICT_BURST;
  assign dm_we = (state == REFILL && fml_ack) || state == REFILL_BURST;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      req_ack <= 1'b0;
      tm_we <= 1'b0;
      tm_di <= '0;
      fml_stb <= 1'b0;
      fml_we <= 1'b0;
      fml_adr <= '0;
      dm_beat <= 2'd0;
      tm_a_q <= '0;
    end else begin
      req_ack <= 1'b0;
      tm_we <= 1'b0;
      tm_a_q <= tm_a;
      if (dm_re || dm_we) dm_beat <= dm_beat + 2'd1;
      case (state)
        IDLE: if (req_stb) state <= TEST;
        TEST: begin
          if (hit) begin
            state <= IDLE;
            req_ack <= 1'b1;
            tm_we <= req_we && !dirty;
            tm_di <= {2'b11, tag};
          end else if (tm_do[tag_width+1] && dirty) begin
            state <= EVICT;
            fml_stb <= 1'b1;
            fml_we <= 1'b1;
            fml_adr <= {tm_do[tag_width-1:0], index, {offset_width{1'b0}}};
          end else begin
            state <= REFILL;
            fml_stb <= 1'b1;
            fml_we <= 1'b0;
            fml_adr <= {tag, index, {offset_width{1'b0}}};
          end
        end
        EVICT: if (fml_ack) begin
          state <= EVICT_BURST;
          fml_stb <= 1'b0;
        end
        EVICT_BURST: if (dm_beat == 2'd3) begin
          state <= REFILL;
          fml_stb <= 1'b1;
          fml_we <= 1'b0;
          fml_adr <= {tag, index, {offset_width{1'b0}}};
        end
        REFILL: if (fml_ack) begin
          state <= REFILL_BURST;
          fml_stb <= 1'b0;
        end
        REFILL_BURST: if (dm_beat == 2'd3) begin
          state <= UPDATE;
          tm_we <= 1'b1;
          tm_di <= {2'b10, tag};
        end
        UPDATE: state <= TEST;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmlbrg_tagctl.sv
// tb_fmlbrg_tagctl: directed vector bench with a write-first tag memory model and an FML ack responder
module tb_fmlbrg_tagctl;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic req_stb = 1'b0;
  logic req_we = 1'b0;
  logic [25:0] req_adr = '0;
  logic req_ack;
  logic [8:0] tm_a;
  logic tm_we;
  logic [13:0] tm_di;
  logic [13:0] tm_do = '0;
  logic [25:0] fml_adr;
  logic fml_stb;
  logic fml_we;
  logic fml_ack = 1'b0;
  logic dm_re;
  logic dm_we;
  logic [1:0] dm_beat;
  logic [13:0] mem [512];
  int ack_delay = 0;
  int stb_cnt = 0;
  int total = 0;
  int passed = 0;
  typedef struct {
    string name;
    logic [25:0] adr;
    logic we;
    int d;
    int lat;
    int ev;
    int rf;
    logic [25:0] eadr;
    logic [25:0] radr;
    int tw;
    logic [13:0] tdi;
  } vec_t;
  vec_t tbl [11];
  vec_t retry;
  fmlbrg_tagctl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_stb(req_stb), .req_we(req_we), .req_adr(req_adr), .req_ack(req_ack),
    .tm_a(tm_a), .tm_we(tm_we), .tm_di(tm_di), .tm_do(tm_do),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
    .dm_re(dm_re), .dm_we(dm_we), .dm_beat(dm_beat)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    if (tm_we) mem[tm_a] <= tm_di;
    tm_do <= tm_we ? tm_di : mem[tm_a];
  end
  always @(negedge sys_clk) begin
    fml_ack = fml_stb && stb_cnt == ack_delay;
    stb_cnt = (fml_stb && !fml_ack) ? stb_cnt + 1 : 0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  task automatic run(input vec_t v);
    int lat = 0, ev = 0, rf = 0, tw = 0, stb = 0, serr = 0, berr = 0, exp_stb;
    logic [25:0] eadr = '0, radr = '0, padr = '0;
    logic [13:0] tdi = '0;
    logic done = 1'b0, pstb = 1'b0, pack = 1'b0;
    ack_delay = v.d;
    @(negedge sys_clk);
    req_stb = 1'b1;
    req_we = v.we;
    req_adr = v.adr;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge sys_clk);
      #1;
      if (dm_re) begin
        if (dm_beat != 2'(ev)) berr++;
        ev++;
      end
      if (dm_we) begin
        if (dm_beat != 2'(rf)) berr++;
        rf++;
      end
      if (fml_stb) begin
        stb++;
        if (fml_we) eadr = fml_adr;
        else radr = fml_adr;
      end
      if (pstb && fml_stb && fml_adr != padr) serr++;
      if (pstb && !fml_stb && !pack) serr++;
      if (tm_we) begin
        tw++;
        tdi = tm_di;
      end
      if (req_ack) begin
        done = 1'b1;
        lat = n;
        req_stb = 1'b0;
      end
      pstb = fml_stb;
      padr = fml_adr;
      pack = fml_ack;
    end
    req_stb = 1'b0;
    exp_stb = (v.ev != 0 ? v.d + 1 : 0) + (v.rf != 0 ? v.d + 1 : 0);
    chk({v.name, ".done"}, done, 1);
    chk({v.name, ".lat"}, lat, v.lat);
    chk({v.name, ".evict_beats"}, ev, v.ev);
    chk({v.name, ".refill_beats"}, rf, v.rf);
    chk({v.name, ".evict_adr"}, eadr, v.eadr);
    chk({v.name, ".refill_adr"}, radr, v.radr);
    chk({v.name, ".tm_we_cnt"}, tw, v.tw);
    chk({v.name, ".tm_di"}, tdi, v.tdi);
    chk({v.name, ".stb_cycles"}, stb, exp_stb);
    chk({v.name, ".stb_stable"}, serr, 0);
    chk({v.name, ".beat_order"}, berr, 0);
  endtask
  initial begin
    logic found;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    tbl[0]  = '{"miss_refill", 26'h0012340, 1'b0, 3, 11, 0, 4, 26'h0, 26'h0012340, 1, 14'h2004};
    tbl[1]  = '{"rd_hit",      26'h0012340, 1'b0, 0, 2, 0, 0, 26'h0, 26'h0, 0, 14'h0};
    tbl[2]  = '{"wr_hit",      26'h0012340, 1'b1, 0, 2, 0, 0, 26'h0, 26'h0, 1, 14'h3004};
    tbl[3]  = '{"wr_hit2",     26'h0012340, 1'b1, 0, 2, 0, 0, 26'h0, 26'h0, 0, 14'h0};
    tbl[4]  = '{"dirty_evict", 26'h0052340, 1'b0, 1, 14, 4, 4, 26'h0012340, 26'h0052340, 1, 14'h2014};
    tbl[5]  = '{"rd_hit_off",  26'h0052344, 1'b0, 0, 2, 0, 0, 26'h0, 26'h0, 0, 14'h0};
    tbl[6]  = '{"wr_miss",     26'h0000020, 1'b1, 0, 8, 0, 4, 26'h0, 26'h0000020, 2, 14'h3000};
    tbl[7]  = '{"top_line",    26'h3FFFFE0, 1'b0, 2, 10, 0, 4, 26'h0, 26'h3FFFFE0, 1, 14'h2FFF};
    tbl[8]  = '{"top_hit",     26'h3FFFFFF, 1'b0, 0, 2, 0, 0, 26'h0, 26'h0, 0, 14'h0};
    tbl[9]  = '{"evict_idx1",  26'h1000020, 1'b0, 0, 12, 4, 4, 26'h0000020, 26'h1000020, 1, 14'h2400};
    tbl[10] = '{"stall",       26'h0100040, 1'b0, 20, 28, 0, 4, 26'h0, 26'h0100040, 1, 14'h2040};
    retry   = '{"rst_retry",   26'h0200060, 1'b0, 1, 9, 0, 4, 26'h0, 26'h0200060, 1, 14'h2080};
    repeat (3) @(negedge sys_clk);
    #1;
    chk("reset.strobes", {req_ack, tm_we, fml_stb, fml_we, dm_re, dm_we}, 0);
    chk("reset.dm_beat", dm_beat, 0);
    chk("reset.fml_adr", fml_adr, 0);
    chk("reset.tm_a", tm_a, 0);
    sys_rst = 1'b0;
    for (int i = 0; i < 11; i++) run(tbl[i]);
    ack_delay = 1;
    @(negedge sys_clk);
    req_stb = 1'b1;
    req_we = 1'b0;
    req_adr = 26'h0200060;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge sys_clk);
      #1;
      if (dm_we && dm_beat == 2'd2) found = 1'b1;
    end
    chk("rst.reach_beat2", found, 1);
    sys_rst = 1'b1;
    req_stb = 1'b0;
    @(negedge sys_clk);
    #1;
    chk("rst.strobes", {req_ack, tm_we, fml_stb, dm_re, dm_we}, 0);
    chk("rst.dm_beat", dm_beat, 0);
    sys_rst = 1'b0;
    chk("rst.tag_kept", mem[3], 0);
    run(retry);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fmlbrg_tagctl.md
Name: fmlbrg_tagctl

Overview:
- Cache-line controller for the FML bridge; sits directly downstream of the tag memory and consumes its read port.
- Per request it addresses the tag memory, compares the returned tag and reports a hit.
- On a miss it runs the FML write-back burst (dirty victim) and the refill burst, then rewrites the tag entry.
- It drives the beat strobes the bridge data memory needs during bursts.

Parameters:
- fml_depth, 26, byte address width of FML and of requests.
- depth, 9, tag memory index bits (2^depth lines).
- offset_width, 5, line offset bits (32-byte line = 4 beats of 64 bits).
- Derived: tag_width = fml_depth - depth - offset_width (12 at defaults). Tag entry = {valid, dirty, tag}, width tag_width+2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; synchronous, active-high.
- req_stb  in  1  request strobe; sampled only in IDLE.
- req_we  in  1  request is a write.
- req_adr  in  fml_depth  request byte address; held stable until req_ack.
- req_ack  out  1  one-cycle pulse: line present, data memory access may complete.
- tm_a  out  depth  tag memory address (registered read, data valid the next cycle).
- tm_we  out  1  tag memory write enable.
- tm_di  out  tag_width+2  tag entry to write {valid, dirty, tag}.
- tm_do  in  tag_width+2  tag entry read for the previous cycle's tm_a.
- fml_adr  out  fml_depth  burst address, low offset_width bits zero.
- fml_stb  out  1  FML burst request.
- fml_we  out  1  1 = write-back, 0 = refill.
- fml_ack  in  1  FML accepts burst; beat 0 is in this cycle.
- dm_re  out  1  data memory read strobe (evict beats).
- dm_we  out  1  data memory write strobe (refill beats).
- dm_beat  out  2  beat index within the line.

Behaviour:
- Address split: offset = adr[offset_width-1:0], index = adr[offset_width+depth-1:offset_width], tag = upper tag_width bits.
- Reset: state IDLE. req_ack, tm_we, fml_stb, fml_we, dm_re, dm_we = 0; dm_beat = 0; fml_adr = 0; tm_a = 0. Tag contents are untouched.
- A reset asserted mid-burst drops fml_stb immediately. The line is left with its old tag entry.
- tm_a = index of req_adr in every state except IDLE-without-request, where it holds.
- IDLE: on req_stb -> TEST.
- TEST:
  - Hit = tm_do.valid and tm_do.tag == req tag.
  - On hit: req_ack = 1 for exactly one cycle, then IDLE. If req_we and not already dirty, the same cycle asserts tm_we with tm_di = {1,1,tag}.
  - On miss with valid and dirty: EVICT, fml_adr = {tm_do.tag, index, 0}, fml_we = 1.
  - Any other miss: REFILL, fml_adr = {req tag, index, 0}, fml_we = 0.
- EVICT:
  - fml_stb held high until fml_ack. The ack cycle is beat 0, dm_re = 1, dm_beat = 0.
  - Go to EVICT_BURST for beats 1..3 (dm_re = 1, dm_beat increments), then REFILL.
- REFILL:
  - fml_stb = 1, fml_we = 0 until fml_ack. The ack cycle is beat 0 with dm_we = 1.
  - Go to REFILL_BURST for beats 1..3, then UPDATE.
- UPDATE: tm_we = 1, tm_di = {1,0,req tag} for one cycle, then TEST. The retest hits and handles the dirty mark.
- Minimum latencies:
  - Hit: req_stb at cycle 0 -> req_ack at cycle 2.
  - Clean miss: ack at 2 + (cycles to fml_ack) + 4 + 2.
- fml_stb never drops before fml_ack. Outputs other than req_ack carry no meaning in IDLE.
- req_stb still high in the cycle after req_ack is taken as a new request.
- dm_beat wraps 3 -> 0 only at burst end.

Test Plan (defaults, adr 26'h0012340: index 0x11A, tag 0x004):
- Tags zeroed, read adr 0x12340 -> REFILL, fml_adr 0x12340, fml_we 0. fml_ack after 3 cycles -> dm_we for 4 cycles with dm_beat 0,1,2,3. Then tm_we with tm_di = {1,0,0x004}, then req_ack.
- Repeat read of the same address -> req_ack exactly 2 cycles after req_stb, no fml_stb.
- Write hit to 0x12340 -> req_ack with tm_we, tm_di = {1,1,0x004}. A second write hit -> no tm_we.
- Dirty line, read 26'h0052340 (tag 0x014):
  - First EVICT: fml_adr 0x12340, fml_we 1, dm_re for 4 beats.
  - Then REFILL: fml_adr 0x52340.
  - Final entry {1,0,0x014}.
- Hold fml_ack low for 20 cycles during REFILL -> fml_stb stays high and fml_adr stays stable the whole time.
- Assert sys_rst during REFILL_BURST beat 2 -> next cycle IDLE, all strobes 0, dm_beat 0. A new read retries the refill.
